// File: rtl/pipwb_ext_rv32_if.sv
// pipwb_ext_rv32_if -- MEM-to-WriteBack bundle and register-file write port.
//   master : drives the MEM bundle (iVALID .. iADDRLO), observes the WB outputs.
//   slave  : the WriteBack stage; consumes the bundle, drives oDregWE/ADDR/DATA,
//            oLDERR and oRETIRED.
// Clock and reset are plain ports on the stage and are not carried here.
interface pipwb_ext_rv32_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
);
  logic             iVALID;
  logic             iSTALL;
  logic             iFLUSH;
  logic [AW-1:0]    iDregADDR;
  logic [1:0]       iWBSEL;
  logic [XLEN-1:0]  iALUDATA;
  logic [XLEN-1:0]  iLOADDATA;
  logic [XLEN-1:0]  iPC4;
  logic [2:0]       iFUNCT3;
  logic [1:0]       iADDRLO;
  logic             oDregWE;
  logic [AW-1:0]    oDregADDR;
  logic [XLEN-1:0]  oDregDATA;
  logic             oLDERR;
  logic [CNT_W-1:0] oRETIRED;

  modport master (
    output iVALID, iSTALL, iFLUSH, iDregADDR, iWBSEL, iALUDATA, iLOADDATA,
           iPC4, iFUNCT3, iADDRLO,
    input  oDregWE, oDregADDR, oDregDATA, oLDERR, oRETIRED
  );

  modport slave (
    input  iVALID, iSTALL, iFLUSH, iDregADDR, iWBSEL, iALUDATA, iLOADDATA,
           iPC4, iFUNCT3, iADDRLO,
    output oDregWE, oDregADDR, oDregDATA, oLDERR, oRETIRED
  );
endinterface

// File: rtl/pipwb_ext_rv32.sv
// pipwb_ext_rv32 -- registered RV32 WriteBack stage between MEM and the regfile.
// Selects ALU / load / PC+4 as the result, aligns and extends sub-word loads,
// flags misaligned or illegal loads, suppresses x0 writes, honours stall and
// flush, and counts retired instructions. Every output is registered (1 cycle).
// Ports:
//   iCLK : clock, rising edge
//   iRST : synchronous reset, active-high
//   bus  : pipwb_ext_rv32_if slave modport (MEM bundle in, regfile write out)
module pipwb_ext_rv32 #(
  parameter int XLEN          = 32,
  parameter int AW            = 5,
  parameter int CNT_W         = 32,
  parameter int ZERO_SUPPRESS = 1
) (
  input logic               iCLK,
  input logic               iRST,
  pipwb_ext_rv32_if.slave   bus
);

  logic [XLEN-1:0]  lane_s;
  logic [XLEN-1:0]  ldData_s;
  logic             ldLegal_s;
  logic             writeOk_s;

  logic             dregWe_r;
  logic [AW-1:0]    dregAddr_r;
  logic [XLEN-1:0]  dregData_r;
  logic             ldErr_r;
  logic [CNT_W-1:0] retired_r;

  // Load alignment/extension and the x0 write-enable qualifier.
  always_comb begin
    ldData_s  = {XLEN{1'b0}};
    ldLegal_s = 1'b0;
    // Shift the addressed byte/halfword down to bit 0.
    lane_s    = bus.iLOADDATA >> {bus.iADDRLO, 3'b000};
    case (bus.iFUNCT3)
      3'b000: begin
        ldData_s  = {{(XLEN-8){lane_s[7]}}, lane_s[7:0]};
        ldLegal_s = 1'b1;
      end
      3'b100: begin
        ldData_s  = {{(XLEN-8){1'b0}}, lane_s[7:0]};
        ldLegal_s = 1'b1;
      end
      3'b001: begin
        ldData_s  = {{(XLEN-16){lane_s[15]}}, lane_s[15:0]};
        ldLegal_s = ~bus.iADDRLO[0];
      end
      3'b101: begin
        ldData_s  = {{(XLEN-16){1'b0}}, lane_s[15:0]};
        ldLegal_s = ~bus.iADDRLO[0];
      end
      3'b010: begin
        ldData_s  = lane_s;
        ldLegal_s = (bus.iADDRLO == 2'b00);
      end
      default: begin
        ldData_s  = {XLEN{1'b0}};
        ldLegal_s = 1'b0;
      end
    endcase
    // x0 writes still update DATA and retire; only the enable is dropped.
    if ((ZERO_SUPPRESS != 32'sd0) && (bus.iDregADDR == {AW{1'b0}})) begin
      writeOk_s = 1'b0;
    end else begin
      writeOk_s = 1'b1;
    end
  end

  // Output registers and retire counter: reset > flush > stall > capture.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      dregWe_r   <= 1'b0;
      dregAddr_r <= {AW{1'b0}};
      dregData_r <= {XLEN{1'b0}};
      ldErr_r    <= 1'b0;
      retired_r  <= {CNT_W{1'b0}};
    end else if (bus.iFLUSH || bus.iSTALL || !bus.iVALID) begin
      // Bubble: a held bundle must not be written twice; ADDR/DATA hold.
      dregWe_r <= 1'b0;
      ldErr_r  <= 1'b0;
    end else begin
      dregAddr_r <= bus.iDregADDR;
      case (bus.iWBSEL)
        2'b00: begin
          dregData_r <= bus.iALUDATA;
          dregWe_r   <= writeOk_s;
          ldErr_r    <= 1'b0;
          retired_r  <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        2'b01: begin
          if (ldLegal_s) begin
            dregData_r <= ldData_s;
            dregWe_r   <= writeOk_s;
            ldErr_r    <= 1'b0;
            retired_r  <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            // Faulting load: no write, no retire, DATA keeps its old value.
            dregWe_r <= 1'b0;
            ldErr_r  <= 1'b1;
          end
        end
        2'b10: begin
          dregData_r <= bus.iPC4;
          dregWe_r   <= writeOk_s;
          ldErr_r    <= 1'b0;
          retired_r  <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        2'b11: begin
          // Store/branch: retires without a register write.
          dregWe_r  <= 1'b0;
          ldErr_r   <= 1'b0;
          retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: begin
          dregWe_r <= 1'b0;
          ldErr_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oDregWE   = dregWe_r;
  assign bus.oDregADDR = dregAddr_r;
  assign bus.oDregDATA = dregData_r;
  assign bus.oLDERR    = ldErr_r;
  assign bus.oRETIRED  = retired_r;

endmodule
